// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: FSM state encoding, next-PC
// select codes and default reset/exception vectors.
package pc_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2,
      ST_HALT  = 2'd3
   } state_t;

   typedef enum logic [2:0] {
      SEL_SEQ = 3'd0,
      SEL_BR  = 3'd1,
      SEL_J   = 3'd2,
      SEL_JR  = 3'd3,
      SEL_EXC = 3'd4
   } next_sel_t;

   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0040_0000;
   localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h8000_0180;

   // A register jump target must be word aligned; anything else faults.
   function automatic logic jr_misaligned(input logic [1:0] low_bits);
      return low_bits != 2'b00;
   endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection: priority encode the redirect sources and
// compute the chosen target address.
module pc_next_sel
   import pc_sequencer_pkg::*;
#(
   parameter int                N_BITS     = 32,
   parameter logic [N_BITS-1:0] EXC_VECTOR = N_BITS'(DEFAULT_EXC_VECTOR)
) (
   input  logic [N_BITS-1:0] pc_plus4,
   input  logic              branch_taken,
   input  logic [15:0]       branch_offset,
   input  logic              jump,
   input  logic [25:0]       jump_index,
   input  logic              jr,
   input  logic [N_BITS-1:0] jr_target,
   input  logic              exception,
   output next_sel_t         sel,
   output logic [N_BITS-1:0] next_pc
);

   logic [N_BITS-1:0] branch_disp;
   logic [N_BITS-1:0] jump_target;

   assign branch_disp = {{(N_BITS-18){branch_offset[15]}}, branch_offset, 2'b00};
   assign jump_target = {pc_plus4[N_BITS-1:28], jump_index, 2'b00};

   // Exception wins over everything, and a misaligned JR is treated as one.
   always_comb begin
      sel = SEL_SEQ;
      if (exception || (jr && jr_misaligned(jr_target[1:0]))) begin
         sel = SEL_EXC;
      end else if (jr) begin
         sel = SEL_JR;
      end else if (jump) begin
         sel = SEL_J;
      end else if (branch_taken) begin
         sel = SEL_BR;
      end
   end

   always_comb begin
      next_pc = pc_plus4;
      case (sel)
         SEL_EXC: next_pc = EXC_VECTOR;
         SEL_JR:  next_pc = jr_target;
         SEL_J:   next_pc = jump_target;
         SEL_BR:  next_pc = pc_plus4 + branch_disp;
         default: next_pc = pc_plus4;
      endcase
   end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/commit sequencer owning the program counter: handshakes each fetch,
// waits for commit, then registers the selected next PC.
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter int                N_BITS       = 32,
   parameter logic [N_BITS-1:0] RESET_VECTOR = N_BITS'(DEFAULT_RESET_VECTOR),
   parameter logic [N_BITS-1:0] EXC_VECTOR   = N_BITS'(DEFAULT_EXC_VECTOR)
) (
   input  logic              clk,
   input  logic              reset,
   output logic              fetch_req_o,
   output logic [N_BITS-1:0] fetch_addr_o,
   input  logic              fetch_ack_i,
   input  logic              commit_i,
   input  logic              branch_taken_i,
   input  logic [15:0]       branch_offset_i,
   input  logic              jump_i,
   input  logic [25:0]       jump_index_i,
   input  logic              jr_i,
   input  logic [N_BITS-1:0] jr_target_i,
   input  logic              exception_i,
   input  logic              halt_i,
   output logic [N_BITS-1:0] pc_o,
   output logic [N_BITS-1:0] pc_plus4_o,
   output logic [N_BITS-1:0] epc_o,
   output logic [31:0]       instr_count_o,
   output logic [1:0]        state_o
);

   state_t            state_q;
   state_t            state_d;
   logic              commit_fire;
   next_sel_t         sel;
   logic [N_BITS-1:0] pc_q;
   logic [N_BITS-1:0] epc_q;
   logic [N_BITS-1:0] pc_plus4;
   logic [N_BITS-1:0] next_pc;
   logic [31:0]       count_q;

   assign pc_plus4 = pc_q + N_BITS'(4);

   pc_next_sel #(
      .N_BITS     (N_BITS),
      .EXC_VECTOR (EXC_VECTOR)
   ) u_next_sel (
      .pc_plus4      (pc_plus4),
      .branch_taken  (branch_taken_i),
      .branch_offset (branch_offset_i),
      .jump          (jump_i),
      .jump_index    (jump_index_i),
      .jr            (jr_i),
      .jr_target     (jr_target_i),
      .exception     (exception_i),
      .sel           (sel),
      .next_pc       (next_pc)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Commit is only honoured in EXEC; ack only in FETCH; HALT is absorbing.
   always_comb begin
      state_d     = state_q;
      commit_fire = 1'b0;
      case (state_q)
         ST_IDLE:  state_d = ST_FETCH;
         ST_FETCH: if (fetch_ack_i) state_d = ST_EXEC;
         ST_EXEC: begin
            if (commit_i) begin
               commit_fire = 1'b1;
               state_d     = halt_i ? ST_HALT : ST_FETCH;
            end
         end
         ST_HALT:  state_d = ST_HALT;
         default:  state_d = ST_IDLE;
      endcase
   end

   // A faulting instruction records its PC but does not count as retired.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q    <= RESET_VECTOR;
         epc_q   <= '0;
         count_q <= '0;
      end else if (commit_fire) begin
         pc_q <= next_pc;
         if (sel == SEL_EXC) begin
            epc_q <= pc_q;
         end else begin
            count_q <= count_q + 32'd1;
         end
      end
   end

   assign fetch_req_o   = (state_q == ST_FETCH);
   assign fetch_addr_o  = pc_q;
   assign pc_o          = pc_q;
   assign pc_plus4_o    = pc_plus4;
   assign epc_o         = epc_q;
   assign instr_count_o = count_q;
   assign state_o       = state_q;

endmodule
